stream_playback: RTL and testbench
==================================

# stream_playback

Stream injector that is the transmit-side counterpart of stream capture: software loads a block-RAM buffer through APB, then the block replays those words as a valid/ready stream. It sits at a stream input of the design under debug, driving test patterns in place of, or muxed with, the normal source. APB registers control start, length, loop mode and soft reset, and expose progress.

## Interface
- DataBits, 8, width of each stream word and memory entry
- MemDepth, 1024, number of memory entries; MemAddrBits = clog2(MemDepth)
- clk  in  1  clock
- rst  in  1  reset rst, synchronous, active-high; clock clk
- dout_data  out  DataBits  stream data
- dout_valid  out  1  stream valid
- dout_ready  in  1  stream ready from consumer
- cfg_paddr  in  3+MemAddrBits  APB byte address; word address = paddr>>2
- cfg_psel, cfg_penable, cfg_pwrite  in  1 each  APB control
- cfg_pwdata  in  32  APB write data
- cfg_pready  out  1  APB ready
- cfg_prdata  out  32  APB read data
- cfg_pslverr  out  1  tied 0

## Operation
- Word address map, A = 2**MemAddrBits: 0..MemDepth-1 memory (write-only, reads return 0); A+0 Enable RW bit0; A+1 Reset RW bit0; A+2 Length RW [MemAddrBits:0]; A+3 Loop RW bit0; A+4 Count RO 16-bit; A+5 RPtr RO; A+6 Status RO (bit0 busy, bit1 done).
- APB: action taken in setup cycle (psel & !penable); cfg_pready pulses 1 the following cycle for every access. Unmapped addresses: write ignored, read returns 0.
- FSM: IDLE -> RUN on rising edge of Enable (rptr=0, run counter=0, done=0). RUN -> DONE when Length words handshaken (valid&ready) and Loop=0. RUN -> DRAIN when Enable falls; DRAIN -> IDLE when buffer empty. DONE -> IDLE when Enable falls.
- Length 0: rising Enable goes straight to DONE, no dout_valid. Length > MemDepth clamped to MemDepth.
- Prefetch: 2-entry output buffer; a RAM read is issued when buffer occupancy + reads in flight < 2 and words remain in the run; rptr advances per read, wraps to 0 at Length-1 (Loop) or stops.
- Once dout_valid=1 it holds with stable dout_data until handshake, except on rst/soft reset.
- DRAIN: no new reads; the at most 2 prefetched words are still delivered and counted.
- Count increments per handshake, wraps at 2**16; cleared only by rst or soft reset.
- Soft reset (Reset=1): buffer flushed, dout_valid=0, rptr=0, Count=0, FSM IDLE, held while Reset=1; Enable register unchanged, a new rising edge required to start.
- Memory writes during playback allowed; words already prefetched unaffected; same-cycle write/read of one address returns undefined data (software must avoid).

## Timing
- Reset values: dout_valid=0, dout_data=0, cfg_pready=0, cfg_prdata=0, Enable=Reset=Loop=0, Length=0, Count=0, rptr=0, Status=0.
- Enable written 1 in setup cycle N: first dout_valid=1 in cycle N+3.
- Sustained throughput 1 word/cycle with dout_ready held 1, including across the loop wrap.
- busy=1 in RUN/DRAIN; done=1 in DONE only.

## Configuration
- STREAM_PLAYBACK_LOOP_EN defined: Loop register and wrap-to-0 looping implemented as above.
- Not defined: Loop reads 0, writes ignored, every run ends in DONE after Length words.

## Structure
- Shared package/header: register word offsets (Enable..Status relative to A), Status bit positions, FSM state encodings, shared with stream capture's map.
- Sub-module: existing ram_1r_1w (Width=DataBits, Depth=MemDepth), write port from APB, read port from prefetch logic. Output buffer and FSM inline.

## Test plan
- DataBits=8, MemDepth=16: load 0x10..0x1F, Length=16, Enable=1, ready=1 -> 16 consecutive words 0x10..0x1F, first at N+3, then done=1, Count=16.
- Same, ready toggling 1,0 each cycle -> identical sequence, valid never drops before handshake, data stable while stalled.
- Loop=1 (macro defined), Length=4 -> 0x10,0x11,0x12,0x13,0x10,... without gaps; Enable=0 -> ≤2 further words then busy=0.
- Length=0 -> no dout_valid, done=1 in cycle after Enable takes effect; Length=20 -> 16 words.
- Soft reset mid-run with valid=1, ready=0 -> dout_valid=0 next cycle, Count=0, RPtr=0; re-enable restarts at 0x10.
- Macro undefined: write Loop=1, read back 0; Length=4 run stops after 4 words.

Source files
------------

// File: rtl/stream_playback_pkg.sv
// Shared definitions for the stream playback / stream capture register map.
// Register word offsets are relative to A = 2**MemAddrBits (first word past memory).
package stream_playback_pkg;

  // Register word offsets relative to the register base
  localparam int unsigned REG_ENABLE = 0;
  localparam int unsigned REG_RESET  = 1;
  localparam int unsigned REG_LENGTH = 2;
  localparam int unsigned REG_LOOP   = 3;
  localparam int unsigned REG_COUNT  = 4;
  localparam int unsigned REG_RPTR   = 5;
  localparam int unsigned REG_STATUS = 6;

  // Status register bit positions
  localparam int unsigned STATUS_BUSY_BIT = 0;
  localparam int unsigned STATUS_DONE_BIT = 1;

  // Width of the handshake counter
  localparam int unsigned COUNT_BITS = 16;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } pb_state_e;

endpackage

// File: rtl/ram_1r_1w.sv
// Simple dual-port RAM: one synchronous write port, one registered read port.
// Ports: clk; we/waddr/wdata write port; re/raddr read request; rdata valid the
// cycle after re.
module ram_1r_1w #(
  parameter int unsigned Width = 8,
  parameter int unsigned Depth = 1024
) (
  input  logic                     clk,
  input  logic                     we,
  input  logic [$clog2(Depth)-1:0] waddr,
  input  logic [Width-1:0]         wdata,
  input  logic                     re,
  input  logic [$clog2(Depth)-1:0] raddr,
  output logic [Width-1:0]         rdata
);

  logic [Width-1:0] mem [Depth];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    if (re) rdata <= mem[raddr];
  end

endmodule

// File: rtl/stream_playback.sv
// Stream playback: replays an APB-loaded buffer as a valid/ready stream.
// Ports: clk, rst (sync, active-high); dout_* stream output; cfg_* APB slave.
// Optional feature: STREAM_PLAYBACK_LOOP_EN enables the Loop register and
// wrap-around replay; without it Loop reads 0 and every run ends in DONE.
module stream_playback
  import stream_playback_pkg::*;
#(
  parameter int unsigned DataBits = 8,
  parameter int unsigned MemDepth = 1024
) (
  input  logic                          clk,
  input  logic                          rst,
  output logic [DataBits-1:0]           dout_data,
  output logic                          dout_valid,
  input  logic                          dout_ready,
  input  logic [$clog2(MemDepth)+2:0]   cfg_paddr,
  input  logic                          cfg_psel,
  input  logic                          cfg_penable,
  input  logic                          cfg_pwrite,
  input  logic [31:0]                   cfg_pwdata,
  output logic                          cfg_pready,
  output logic [31:0]                   cfg_prdata,
  output logic                          cfg_pslverr
);

  localparam int unsigned AW      = $clog2(MemDepth);
  localparam int unsigned LW      = AW + 1;
  localparam int unsigned RegBase = 1 << AW;

  localparam logic [LW-1:0] A_ENABLE = LW'(RegBase + REG_ENABLE);
  localparam logic [LW-1:0] A_RESET  = LW'(RegBase + REG_RESET);
  localparam logic [LW-1:0] A_LENGTH = LW'(RegBase + REG_LENGTH);
  localparam logic [LW-1:0] A_LOOP   = LW'(RegBase + REG_LOOP);
  localparam logic [LW-1:0] A_COUNT  = LW'(RegBase + REG_COUNT);
  localparam logic [LW-1:0] A_RPTR   = LW'(RegBase + REG_RPTR);
  localparam logic [LW-1:0] A_STATUS = LW'(RegBase + REG_STATUS);

  pb_state_e              state_q, state_d;
  logic [LW-1:0]          word_addr;
  logic                   setup, wr, rd, mem_we;
  logic                   en_q, en_d, sw_rst_q, loop_q;
  logic [LW-1:0]          len_q, len_eff;
  logic [COUNT_BITS-1:0]  cnt_q;
  logic [LW-1:0]          rptr_q, rptr_inc, rptr_nxt, run_cnt_q;
  logic [AW-1:0]          rd_addr;
  logic                   rise, soft_clr, pop, words_left;
  logic                   rd_issue, rd_start, rd_pend;
  logic [1:0]             occ;
  logic                   buf1_v;
  logic [DataBits-1:0]    buf1_data, ram_rdata;
  logic                   busy, done;
  logic [31:0]            rd_val;
  logic                   unused_ok;

  assign cfg_pslverr = 1'b0;
  assign unused_ok   = ^{cfg_paddr[1:0], cfg_pwdata};

  // APB decode: all actions are taken in the setup cycle
  assign word_addr = cfg_paddr[AW+2:2];
  assign setup     = cfg_psel & ~cfg_penable;
  assign wr        = setup & cfg_pwrite;
  assign rd        = setup & ~cfg_pwrite;
  assign mem_we    = wr & (word_addr < LW'(MemDepth));

  // Soft reset acts in the same cycle it is written so the stream drops next cycle
  assign soft_clr = sw_rst_q | (wr & (word_addr == A_RESET) & cfg_pwdata[0]);
  assign rise     = en_q & ~en_d;
  assign pop      = dout_valid & dout_ready;
  assign len_eff  = (len_q > LW'(MemDepth)) ? LW'(MemDepth) : len_q;
  assign busy     = (state_q == ST_RUN) || (state_q == ST_DRAIN);
  assign done     = (state_q == ST_DONE);

  // Control registers
  always_ff @(posedge clk) begin
    if (rst) begin
      en_q     <= 1'b0;
      sw_rst_q <= 1'b0;
      len_q    <= '0;
    end else if (wr) begin
      case (word_addr)
        A_ENABLE: en_q     <= cfg_pwdata[0];
        A_RESET:  sw_rst_q <= cfg_pwdata[0];
        A_LENGTH: len_q    <= cfg_pwdata[LW-1:0];
        default: ;
      endcase
    end
  end

`ifdef STREAM_PLAYBACK_LOOP_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      loop_q <= 1'b0;
    end else if (wr && (word_addr == A_LOOP)) begin
      loop_q <= cfg_pwdata[0];
    end
  end
`else
  assign loop_q = 1'b0;
`endif

  // Enable edge detector; keeps tracking during soft reset so a fresh edge is needed
  always_ff @(posedge clk) begin
    if (rst) en_d <= 1'b0;
    else     en_d <= en_q;
  end

  // Read-back mux; memory words and unmapped addresses read as zero
  always_comb begin
    rd_val = '0;
    case (word_addr)
      A_ENABLE: rd_val = 32'(en_q);
      A_RESET:  rd_val = 32'(sw_rst_q);
      A_LENGTH: rd_val = 32'(len_q);
      A_LOOP:   rd_val = 32'(loop_q);
      A_COUNT:  rd_val = 32'(cnt_q);
      A_RPTR:   rd_val = 32'(rptr_q);
      A_STATUS: begin
        rd_val[STATUS_BUSY_BIT] = busy;
        rd_val[STATUS_DONE_BIT] = done;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cfg_pready <= 1'b0;
      cfg_prdata <= '0;
    end else begin
      cfg_pready <= setup;
      cfg_prdata <= rd ? rd_val : '0;
    end
  end

  // Buffer slots after this cycle's pop plus reads still in flight
  assign occ        = 2'(dout_valid) + 2'(buf1_v) + 2'(rd_pend) - 2'(pop);
  assign words_left = loop_q | (rptr_q < len_eff);

  // Read address generation; rptr wraps only when looping, otherwise parks at Length
  always_comb begin
    rd_addr  = rd_start ? '0 : rptr_q[AW-1:0];
    rptr_inc = {1'b0, rd_addr} + LW'(1);
    rptr_nxt = (loop_q && (rptr_inc >= len_eff)) ? '0 : rptr_inc;
  end

  // FSM next state and read issue
  always_comb begin
    state_d  = state_q;
    rd_issue = 1'b0;
    rd_start = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (rise) begin
          if (len_eff == '0) begin
            state_d = ST_DONE;
          end else begin
            state_d  = ST_RUN;
            rd_issue = 1'b1;
            rd_start = 1'b1;
          end
        end
      end
      ST_RUN: begin
        if (!en_q) begin
          state_d = ST_DRAIN;
        end else begin
          rd_issue = words_left && (occ < 2'd2);
          if (pop && !loop_q && (run_cnt_q == len_eff - LW'(1))) state_d = ST_DONE;
        end
      end
      ST_DRAIN: begin
        if (!dout_valid && !buf1_v && !rd_pend) state_d = ST_IDLE;
      end
      ST_DONE: begin
        if (!en_q) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
    if (soft_clr) begin
      state_d  = ST_IDLE;
      rd_issue = 1'b0;
      rd_start = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  // Two-entry output buffer: dout_* is the head, buf1 the second slot
  always_ff @(posedge clk) begin
    if (rst) begin
      dout_valid <= 1'b0;
      dout_data  <= '0;
      buf1_v     <= 1'b0;
      buf1_data  <= '0;
      rd_pend    <= 1'b0;
      rptr_q     <= '0;
      run_cnt_q  <= '0;
      cnt_q      <= '0;
    end else if (soft_clr) begin
      dout_valid <= 1'b0;
      buf1_v     <= 1'b0;
      rd_pend    <= 1'b0;
      rptr_q     <= '0;
      run_cnt_q  <= '0;
      cnt_q      <= '0;
    end else begin
      rd_pend <= rd_issue;
      if (rd_issue) rptr_q <= rptr_nxt;
      if (pop) cnt_q <= cnt_q + COUNT_BITS'(1);
      if (rd_start)  run_cnt_q <= '0;
      else if (pop)  run_cnt_q <= run_cnt_q + LW'(1);

      if (pop) begin
        if (buf1_v) begin
          dout_data <= buf1_data;
          buf1_v    <= rd_pend;
          if (rd_pend) buf1_data <= ram_rdata;
        end else begin
          dout_valid <= rd_pend;
          if (rd_pend) dout_data <= ram_rdata;
        end
      end else if (rd_pend) begin
        if (!dout_valid) begin
          dout_valid <= 1'b1;
          dout_data  <= ram_rdata;
        end else begin
          buf1_v    <= 1'b1;
          buf1_data <= ram_rdata;
        end
      end
    end
  end

  ram_1r_1w #(
    .Width (DataBits),
    .Depth (MemDepth)
  ) u_ram (
    .clk   (clk),
    .we    (mem_we),
    .waddr (word_addr[AW-1:0]),
    .wdata (cfg_pwdata[DataBits-1:0]),
    .re    (rd_issue),
    .raddr (rd_addr),
    .rdata (ram_rdata)
  );

endmodule

// File: tb/tb_stream_playback.sv
// Testbench for stream_playback (DataBits=8, MemDepth=16).
module tb_stream_playback;
  import stream_playback_pkg::*;

  localparam int unsigned RegBase = 16;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  dout_data;
  logic        dout_valid, dout_ready;
  logic [6:0]  cfg_paddr;
  logic        cfg_psel, cfg_penable, cfg_pwrite;
  logic [31:0] cfg_pwdata, cfg_prdata;
  logic        cfg_pready, cfg_pslverr;

  always #5 clk = ~clk;

  stream_playback #(.DataBits(8), .MemDepth(16)) dut (
    .clk(clk), .rst(rst),
    .dout_data(dout_data), .dout_valid(dout_valid), .dout_ready(dout_ready),
    .cfg_paddr(cfg_paddr), .cfg_psel(cfg_psel), .cfg_penable(cfg_penable),
    .cfg_pwrite(cfg_pwrite), .cfg_pwdata(cfg_pwdata), .cfg_pready(cfg_pready),
    .cfg_prdata(cfg_prdata), .cfg_pslverr(cfg_pslverr)
  );

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Observation of the stream port: handshakes, valid rises, stall stability
  logic [7:0] hs_data[$];
  int         hs_cyc[$];
  int         vrise_cyc[$];
  int         stall_viol = 0;
  bit         chk_stable = 1'b0;
  logic       pv = 1'b0, pr = 1'b0;
  logic [7:0] pd = '0;

  always @(negedge clk) begin
    if (!rst) begin
      if (dout_valid && dout_ready) begin
        hs_data.push_back(dout_data);
        hs_cyc.push_back(cyc);
      end
      if (dout_valid && !pv) vrise_cyc.push_back(cyc);
      if (chk_stable && pv && !pr && !(dout_valid && dout_data == pd)) stall_viol <= stall_viol + 1;
    end
    pv <= dout_valid;
    pr <= dout_ready;
    pd <= dout_data;
  end

  // Consumer ready pattern: 0 always, 1 toggle, 2 random, else held low
  int ready_mode = 0;
  initial begin
    dout_ready = 1'b0;
    forever begin
      @(posedge clk); #1;
      case (ready_mode)
        0:       dout_ready = 1'b1;
        1:       dout_ready = ~dout_ready;
        2:       dout_ready = 1'($urandom_range(0, 1));
        default: dout_ready = 1'b0;
      endcase
    end
  end

  int          n_chk = 0, n_bad = 0;
  int          last_setup = 0;
  int          exp_cnt = 0;
  logic [7:0]  mem_model [16];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic apb_write(input int unsigned waddr, input logic [31:0] data);
    @(posedge clk); #1;
    last_setup  = cyc;
    cfg_psel    = 1'b1; cfg_penable = 1'b0; cfg_pwrite = 1'b1;
    cfg_paddr   = 7'(waddr << 2); cfg_pwdata = data;
    @(posedge clk); #1;
    cfg_penable = 1'b1;
    @(posedge clk); #1;
    cfg_psel = 1'b0; cfg_penable = 1'b0; cfg_pwrite = 1'b0;
  endtask

  task automatic apb_read(input int unsigned waddr, output logic [31:0] data);
    @(posedge clk); #1;
    cfg_psel  = 1'b1; cfg_penable = 1'b0; cfg_pwrite = 1'b0;
    cfg_paddr = 7'(waddr << 2);
    @(posedge clk); #1;
    cfg_penable = 1'b1;
    check("pready", 32'(cfg_pready), 32'd1);
    data = cfg_prdata;
    @(posedge clk); #1;
    cfg_psel = 1'b0; cfg_penable = 1'b0;
  endtask

  task automatic check_reg(input string tag, input int unsigned off, input logic [31:0] exp);
    logic [31:0] d;
    apb_read(RegBase + off, d);
    check(tag, d, exp);
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wait_hs(input string tag, input int target, input int budget);
    int k = 0;
    while (hs_data.size() < target && k < budget) begin
      @(negedge clk);
      k++;
    end
    check(tag, 32'(hs_data.size() >= target), 32'd1);
  endtask

  // Expected stream: word i of a run is buffer entry (i mod Length)
  task automatic expect_words(input string tag, input int base, input int n, input int len);
    for (int i = 0; i < n; i++)
      check($sformatf("%s_w%0d", tag, i), 32'(hs_data[base + i]), 32'(mem_model[i % len]));
  endtask

  initial begin
    int base, vb, extra, total, len, n;
    logic [31:0] d;
    rst = 1'b1;
    cfg_psel = 1'b0; cfg_penable = 1'b0; cfg_pwrite = 1'b0;
    cfg_paddr = '0; cfg_pwdata = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    // Reset state
    check("rst_valid",  32'(dout_valid), 32'd0);
    check("rst_data",   32'(dout_data),  32'd0);
    check("rst_pready", 32'(cfg_pready), 32'd0);
    check("rst_prdata", cfg_prdata,      32'd0);
    for (int r = 0; r <= 6; r++) check_reg($sformatf("rst_reg%0d", r), r, 32'd0);

    // Load buffer and probe read-as-zero regions
    for (int i = 0; i < 16; i++) begin
      mem_model[i] = 8'(8'h10 + i);
      apb_write(i, 32'(mem_model[i]));
    end
    apb_read(3, d);            check("mem_read_zero", d, 32'd0);
    apb_write(RegBase + 7, 32'hFFFF_FFFF);
    apb_read(RegBase + 7, d);  check("unmapped_read", d, 32'd0);
    apb_write(RegBase + REG_LENGTH, 32'd16);
    check_reg("len_readback", REG_LENGTH, 32'd16);

    // Full-rate run
    ready_mode = 0; chk_stable = 1'b1;
    base = hs_data.size(); vb = vrise_cyc.size();
    apb_write(RegBase + REG_ENABLE, 32'd1);
    n = last_setup;
    wait_hs("t1_timeout", base + 16, 200);
    check("t1_first_valid", 32'(vrise_cyc[vb]), 32'(n + 3));
    check("t1_first_hs",    32'(hs_cyc[base]),  32'(n + 3));
    check("t1_gapless",     32'(hs_cyc[base + 15] - hs_cyc[base]), 32'd15);
    expect_words("t1", base, 16, 16);
    wait_cycles(3);
    check("t1_no_extra", 32'(hs_data.size()), 32'(base + 16));
    exp_cnt += 16;
    check_reg("t1_status", REG_STATUS, 32'd2);
    check_reg("t1_count",  REG_COUNT,  32'(exp_cnt));
    apb_write(RegBase + REG_ENABLE, 32'd0);
    check_reg("t1_status_idle", REG_STATUS, 32'd0);

    // Toggling ready
    ready_mode = 1;
    base = hs_data.size();
    apb_write(RegBase + REG_ENABLE, 32'd1);
    wait_hs("t2_timeout", base + 16, 200);
    wait_cycles(4);
    check("t2_no_extra", 32'(hs_data.size()), 32'(base + 16));
    expect_words("t2", base, 16, 16);
    exp_cnt += 16;
    check_reg("t2_status", REG_STATUS, 32'd2);
    check_reg("t2_count",  REG_COUNT,  32'(exp_cnt));
    apb_write(RegBase + REG_ENABLE, 32'd0);
    ready_mode = 0;

`ifdef STREAM_PLAYBACK_LOOP_EN
    // Loop run, then disable and drain
    apb_write(RegBase + REG_LENGTH, 32'd4);
    apb_write(RegBase + REG_LOOP, 32'd1);
    check_reg("t3_loop_rb", REG_LOOP, 32'd1);
    base = hs_data.size();
    apb_write(RegBase + REG_ENABLE, 32'd1);
    wait_hs("t3_timeout", base + 12, 100);
    check("t3_gapless", 32'(hs_cyc[base + 11] - hs_cyc[base]), 32'd11);
    apb_write(RegBase + REG_ENABLE, 32'd0);
    n = last_setup;
    wait_cycles(8);
    check_reg("t3_busy_clear", REG_STATUS, 32'd0);
    total = hs_data.size() - base;
    extra = 0;
    for (int i = base; i < hs_data.size(); i++) if (hs_cyc[i] > n + 1) extra++;
    check("t3_drain_le2", 32'(extra <= 2), 32'd1);
    expect_words("t3", base, total, 4);
    exp_cnt += total;
    check_reg("t3_count", REG_COUNT, 32'(exp_cnt));
    apb_write(RegBase + REG_LOOP, 32'd0);
`else
    // Loop disabled: register ignores writes, run stops after Length words
    apb_write(RegBase + REG_LOOP, 32'd1);
    check_reg("t3_loop_rb0", REG_LOOP, 32'd0);
    apb_write(RegBase + REG_LENGTH, 32'd4);
    base = hs_data.size();
    apb_write(RegBase + REG_ENABLE, 32'd1);
    wait_hs("t3_timeout", base + 4, 100);
    wait_cycles(10);
    check("t3_stop4", 32'(hs_data.size()), 32'(base + 4));
    expect_words("t3", base, 4, 4);
    exp_cnt += 4;
    check_reg("t3_status", REG_STATUS, 32'd2);
    check_reg("t3_count",  REG_COUNT,  32'(exp_cnt));
    apb_write(RegBase + REG_ENABLE, 32'd0);
`endif

    // Length 0: straight to done, no stream activity
    apb_write(RegBase + REG_LENGTH, 32'd0);
    base = hs_data.size(); vb = vrise_cyc.size();
    apb_write(RegBase + REG_ENABLE, 32'd1);
    check_reg("t4_done", REG_STATUS, 32'd2);
    wait_cycles(5);
    check("t4_no_valid", 32'(vrise_cyc.size()), 32'(vb));
    check("t4_no_hs",    32'(hs_data.size()),   32'(base));
    apb_write(RegBase + REG_ENABLE, 32'd0);

    // Length above depth is clamped
    apb_write(RegBase + REG_LENGTH, 32'd20);
    ready_mode = 2;
    base = hs_data.size();
    apb_write(RegBase + REG_ENABLE, 32'd1);
    wait_hs("t5_timeout", base + 16, 300);
    wait_cycles(10);
    check("t5_clamp16", 32'(hs_data.size()), 32'(base + 16));
    expect_words("t5", base, 16, 16);
    exp_cnt += 16;
    check_reg("t5_status", REG_STATUS, 32'd2);
    check_reg("t5_count",  REG_COUNT,  32'(exp_cnt));
    apb_write(RegBase + REG_ENABLE, 32'd0);

    // Soft reset while stalled
    apb_write(RegBase + REG_LENGTH, 32'd16);
    ready_mode = 3;
    apb_write(RegBase + REG_ENABLE, 32'd1);
    for (int k = 0; k < 20 && !dout_valid; k++) @(negedge clk);
    check("t6_valid_pre", 32'(dout_valid), 32'd1);
    chk_stable = 1'b0;
    apb_write(RegBase + REG_RESET, 32'd1);
    check("t6_valid_drop", 32'(dout_valid), 32'd0);
    exp_cnt = 0;
    check_reg("t6_count", REG_COUNT,  32'd0);
    check_reg("t6_rptr",  REG_RPTR,   32'd0);
    check_reg("t6_stat",  REG_STATUS, 32'd0);
    check_reg("t6_en_kept", REG_ENABLE, 32'd1);
    apb_write(RegBase + REG_RESET, 32'd0);
    chk_stable = 1'b1;
    wait_cycles(5);
    check("t6_no_restart", 32'(dout_valid), 32'd0);
    apb_write(RegBase + REG_ENABLE, 32'd0);
    ready_mode = 0;
    base = hs_data.size();
    apb_write(RegBase + REG_ENABLE, 32'd1);
    wait_hs("t6_timeout", base + 16, 200);
    expect_words("t6", base, 16, 16);
    exp_cnt += 16;
    wait_cycles(3);
    check_reg("t6_count2", REG_COUNT, 32'(exp_cnt));
    apb_write(RegBase + REG_ENABLE, 32'd0);

    // Random contents, length and back-pressure
    for (int it = 0; it < 2; it++) begin
      for (int i = 0; i < 16; i++) begin
        mem_model[i] = 8'($urandom);
        apb_write(i, 32'(mem_model[i]));
      end
      len = $urandom_range(1, 16);
      apb_write(RegBase + REG_LENGTH, 32'(len));
      ready_mode = 2;
      base = hs_data.size();
      apb_write(RegBase + REG_ENABLE, 32'd1);
      wait_hs($sformatf("r%0d_timeout", it), base + len, 300);
      wait_cycles(6);
      check($sformatf("r%0d_len", it), 32'(hs_data.size()), 32'(base + len));
      expect_words($sformatf("r%0d", it), base, len, len);
      exp_cnt += len;
      check_reg($sformatf("r%0d_status", it), REG_STATUS, 32'd2);
      check_reg($sformatf("r%0d_count", it),  REG_COUNT,  32'(exp_cnt));
      apb_write(RegBase + REG_ENABLE, 32'd0);
    end

    check("stall_stable", 32'(stall_viol), 32'd0);
    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
